// File: rtl/digit_decode_drive_pkg.sv
// Shared constants for the digit decoder: 7-segment patterns (active-high,
// {dp,g,f,e,d,c,b,a}), the conversion FSM states and small helpers.
package digit_decode_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_OFF  = 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h40;

  // Non-decimal nibbles render as an unlit digit.
  function automatic logic [7:0] digit_pattern(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  // Double-dabble correction applied to each BCD nibble before the shift.
  function automatic logic [3:0] add3_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/digit_decode_drive_bcd_to_seg.sv
// Combinational nibble-to-segment decoder. Output is active-high; the caller
// applies display polarity and registering.
module bcd_to_seg
  import digit_decode_drive_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg
);

  // Dash takes priority so an overflowed display never goes dark.
  always_comb begin
    seg = digit_pattern(nibble);
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_OFF;
    end
  end

endmodule

// File: rtl/digit_decode_drive.sv
// Binary-to-BCD converter (sequential double-dabble) with latched ones/tens
// digits and a registered, column-multiplexed 7-segment drive.
module digit_decode_drive
  import digit_decode_drive_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Number_In,
  input  logic             Load,
  input  logic [1:0]       Col_Scan_Sig,
  output logic [7:0]       Row_Scan_Sig,
  output logic             Busy,
  output logic             Ovf,
  output state_t           state_dbg
);

  // Handshake: Load is a single-cycle request, accepted only while Busy is low;
  // a Load seen while Busy is high is dropped, never queued.

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0]      ROW_OFF  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  state_t           state_q, state_next;
  logic [WIDTH-1:0] bin_q;
  logic [11:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       ones_q, tens_q;
  logic             ovf_q;
  logic [7:0]       seg_q;

  logic [7:0]       bcd_lo_adj;
  logic [2:0]       hun_adj;
  logic [3:0]       mux_nib;
  logic             mux_blank, mux_dash;
  logic [7:0]       mux_pat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (Load) state_next = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The hundreds bit 3 is shifted out and lost, so only its low 3 bits are kept.
  always_comb begin
    bcd_lo_adj = {add3_ge5(bcd_q[7:4]), add3_ge5(bcd_q[3:0])};
    hun_adj    = (bcd_q[11:8] >= 4'd5) ? bcd_q[10:8] + 3'd3 : bcd_q[10:8];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Load) begin
            bin_q <= Number_In;
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          bcd_q <= {hun_adj, bcd_lo_adj, bin_q[WIDTH-1]};
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          ones_q <= bcd_q[3:0];
          tens_q <= bcd_q[7:4];
          ovf_q  <= (bcd_q[11:8] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // Column mux: 2'b10 = ones, 2'b01 = tens, anything else blanks the bus.
  always_comb begin
    mux_nib   = ones_q;
    mux_blank = 1'b1;
    mux_dash  = 1'b0;
    case (Col_Scan_Sig)
      2'b10: begin
        mux_nib   = ones_q;
        mux_blank = 1'b0;
        mux_dash  = ovf_q;
      end
      2'b01: begin
        mux_nib   = tens_q;
        mux_blank = BLANK_LZ && (tens_q == 4'd0) && !ovf_q;
        mux_dash  = ovf_q;
      end
      default: ;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (mux_nib),
    .blank  (mux_blank),
    .dash   (mux_dash),
    .seg    (mux_pat)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_q <= ROW_OFF;
    end else begin
      seg_q <= SEG_ACTIVE_LOW ? ~mux_pat : mux_pat;
    end
  end

  assign Row_Scan_Sig = seg_q;
  assign Busy         = (state_q != IDLE);
  assign Ovf          = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_digit_decode_drive.sv
// Directed and randomized checks of digit_decode_drive against a decimal
// reference model of the displayed digits.
module tb_digit_decode_drive;
  import digit_decode_drive_pkg::*;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] Number_In = '0;
  logic             Load = 1'b0;
  logic [1:0]       Col_Scan_Sig = 2'b10;
  logic [7:0]       Row_Scan_Sig;
  logic             Busy;
  logic             Ovf;
  state_t           state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the decimal value currently shown.
  int m_ones = 0;
  int m_tens = 0;
  bit m_ovf  = 1'b0;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  digit_decode_drive #(.WIDTH(WIDTH), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Number_In    (Number_In),
    .Load         (Load),
    .Col_Scan_Sig (Col_Scan_Sig),
    .Row_Scan_Sig (Row_Scan_Sig),
    .Busy         (Busy),
    .Ovf          (Ovf),
    .state_dbg    (state_dbg)
  );

  always #10 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_row(input logic [1:0] col);
    logic [7:0] hi;
    hi = 8'h00;
    if (col == 2'b10) hi = m_ovf ? 8'h40 : seg_tab[m_ones];
    else if (col == 2'b01) hi = m_ovf ? 8'h40 : (m_tens == 0 ? 8'h00 : seg_tab[m_tens]);
    return ~hi;
  endfunction

  task automatic show(input string tag, input logic [1:0] col);
    Col_Scan_Sig = col;
    step();
    check(tag, Row_Scan_Sig, exp_row(col));
  endtask

  // Runs one conversion; optionally pokes a second Load on busy cycle poke_cyc.
  task automatic convert(input logic [7:0] v, input int poke_cyc, input logic [7:0] poke_v);
    int cyc;
    Number_In = v;
    Load = 1'b1;
    step();
    Load = 1'b0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == poke_cyc) begin
        Number_In = poke_v;
        Load = 1'b1;
      end
      step();
      Load = 1'b0;
      check("hold_display", Row_Scan_Sig, exp_row(Col_Scan_Sig));
    end
    check("busy_len", cyc, WIDTH + 1);
    m_ones = int'(v) % 10;
    m_tens = (int'(v) / 10) % 10;
    m_ovf  = (v > 8'd99);
    step();
    check("new_digit_latency", Row_Scan_Sig, exp_row(Col_Scan_Sig));
    check("ovf", Ovf, m_ovf);
  endtask

  initial begin
    // Reset: display off, then ones '0' once released.
    RST = 1'b1;
    Col_Scan_Sig = 2'b10;
    step();
    step();
    check("reset_row", Row_Scan_Sig, 8'hFF);
    check("reset_busy", Busy, 1'b0);
    check("reset_ovf", Ovf, 1'b0);
    check("reset_state", state_dbg, IDLE);
    RST = 1'b0;
    step();
    check("reset_ones0", Row_Scan_Sig, 8'hC0);
    show("reset_tens_blank", 2'b01);

    // 47: ones '7', tens '4'.
    Col_Scan_Sig = 2'b10;
    convert(8'd47, 0, 8'd0);
    check("d47_ones", Row_Scan_Sig, 8'hF8);
    show("d47_tens", 2'b01);
    check("d47_tens_val", Row_Scan_Sig, 8'h99);

    // Leading zero blanking.
    convert(8'd5, 0, 8'd0);
    check("d5_tens_blank", Row_Scan_Sig, 8'hFF);
    show("d5_ones", 2'b10);
    check("d5_ones_val", Row_Scan_Sig, 8'h92);

    // Overflow shows dashes on both digits, clears on next conversion.
    convert(8'd200, 0, 8'd0);
    check("d200_ovf", Ovf, 1'b1);
    check("d200_ones_dash", Row_Scan_Sig, 8'hBF);
    show("d200_tens", 2'b01);
    check("d200_tens_dash", Row_Scan_Sig, 8'hBF);
    convert(8'd12, 0, 8'd0);
    check("d12_ovf", Ovf, 1'b0);
    check("d12_tens_val", Row_Scan_Sig, 8'hF9);
    show("d12_ones", 2'b10);
    check("d12_ones_val", Row_Scan_Sig, 8'hA4);

    // Load while busy is dropped.
    convert(8'd33, 3, 8'd88);
    check("busy_drop_ones", Row_Scan_Sig, 8'hB0);
    step();
    check("busy_drop_idle", Busy, 1'b0);

    // Reset mid-conversion, with Load held alongside reset.
    Number_In = 8'd99;
    Load = 1'b1;
    step();
    Load = 1'b0;
    step();
    step();
    step();
    check("mid_busy", Busy, 1'b1);
    RST = 1'b1;
    Load = 1'b1;
    step();
    Load = 1'b0;
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_state", state_dbg, IDLE);
    check("mid_rst_ovf", Ovf, 1'b0);
    RST = 1'b0;
    m_ones = 0;
    m_tens = 0;
    m_ovf  = 1'b0;
    show("mid_rst_illegal11", 2'b11);
    check("mid_rst_off", Row_Scan_Sig, 8'hFF);
    show("mid_rst_ones0", 2'b10);
    show("mid_rst_illegal00", 2'b00);

    // Randomized conversions with random selects and stray Loads.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] v;
      logic [7:0] pv;
      int poke;
      v    = 8'($urandom_range(0, 255));
      pv   = 8'($urandom_range(0, 255));
      poke = (($urandom_range(0, 1)) != 0) ? int'($urandom_range(1, WIDTH + 1)) : 0;
      Col_Scan_Sig = 2'($urandom_range(0, 3));
      convert(v, poke, pv);
      for (int k = 0; k < 3; k++) begin
        show("rand_sel", 2'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
